// File: rtl/sensor_seq_pkg.sv
// Shared types and helpers for the N-channel arrival-order sequencer.
// Holds the state encoding and the lowest-set-bit search used by the tracker.
package sensor_seq_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned MAX_CH     = 8;
  localparam int unsigned MAX_IDX_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StArmed   = 3'd2,
    StActive  = 3'd3,
    StDone    = 3'd4,
    StTimeout = 3'd5
  } state_e;

  // Lowest asserted index wins; returns 0 for an all-zero vector.
  function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(logic [MAX_CH-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = MAX_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arrival_tracker.sv
// Sticky record of which event channels have fired and which fired first.
// Capture is gated by the controller; clear and reset return everything to zero.
module arrival_tracker
  import sensor_seq_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  localparam int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             capture_en,
  input  logic [N_CH-1:0]  evt,
  output logic [N_CH-1:0]  seen_o,
  output logic [IDX_W-1:0] first_o,
  output logic             first_vld_o,
  output logic             all_seen_o
);

  logic [N_CH-1:0]   seen_q, seen_d;
  logic [IDX_W-1:0]  first_q, first_d;
  logic              first_vld_q, first_vld_d;
  logic [MAX_CH-1:0] evt_pad;

  always_comb begin
    evt_pad             = '0;
    evt_pad[N_CH-1:0]   = evt;
    seen_d              = seen_q;
    first_d             = first_q;
    first_vld_d         = first_vld_q;
    if (clear) begin
      seen_d      = '0;
      first_d     = '0;
      first_vld_d = 1'b0;
    end else if (capture_en) begin
      seen_d = seen_q | evt;
      // Only the very first non-empty sample sets the first-arrival index.
      if (!first_vld_q && (|evt)) begin
        first_d     = IDX_W'(lowest_set_idx(evt_pad));
        first_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q      <= '0;
      first_q     <= '0;
      first_vld_q <= 1'b0;
    end else begin
      seen_q      <= seen_d;
      first_q     <= first_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign seen_o      = seen_q;
  assign first_o     = first_q;
  assign first_vld_o = first_vld_q;
  // Looks ahead at this cycle's events so completion is seen on the same edge.
  assign all_seen_o  = &(seen_q | evt);

endmodule

// File: rtl/sensor_seq_ctrl.sv
// Arrival-order sequencer: collects channel events, arms once all are seen,
// then drives a fixed-length actuator pulse; reports done or timeout until cleared.
module sensor_seq_ctrl
  import sensor_seq_pkg::*;
#(
  parameter  int unsigned N_CH    = 4,
  parameter  int unsigned CNT_W   = 8,
  parameter  int unsigned ACT_CYC = 3,
  localparam int unsigned IDX_W   = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    evt_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [CNT_W-1:0]   timeout_i,
  output logic [N_CH-1:0]    seen_o,
  output logic [IDX_W-1:0]   first_o,
  output logic               first_vld_o,
  output logic               act_o,
  output logic               done_o,
  output logic               err_o,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [CNT_W-1:0] ActLast = CNT_W'(ACT_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_q, done_q, err_q;
  logic             trk_clear, trk_capture, all_seen;

  arrival_tracker #(
    .N_CH (N_CH)
  ) u_arrival_tracker (
    .clk         (clk),
    .rst         (rst),
    .clear       (trk_clear),
    .capture_en  (trk_capture),
    .evt         (evt_i),
    .seen_o      (seen_o),
    .first_o     (first_o),
    .first_vld_o (first_vld_o),
    .all_seen_o  (all_seen)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trk_clear   = 1'b0;
    trk_capture = 1'b0;
    if (clr_i) begin
      state_d   = StIdle;
      cnt_d     = '0;
      trk_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          trk_capture = 1'b1;
          cnt_d       = '0;
          if (|evt_i) begin
            state_d = all_seen ? StArmed : StCollect;
          end
        end
        StCollect: begin
          trk_capture = 1'b1;
          // Completion takes precedence over a coincident timeout match.
          if (all_seen) begin
            state_d = StArmed;
          end else if ((timeout_i != '0) && (cnt_q == timeout_i - CNT_W'(1))) begin
            state_d = StTimeout;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StArmed: begin
          if (en_i) begin
            state_d = StActive;
            cnt_d   = '0;
          end
        end
        StActive: begin
          if (cnt_q == ActLast) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StDone, StTimeout: begin
          state_d = state_q;
        end
        default: begin
          state_d   = StIdle;
          cnt_d     = '0;
          trk_clear = 1'b1;
        end
      endcase
    end
  end

  // Status outputs are decoded from the next state so they register with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= (state_d == StActive);
      done_q  <= (state_d == StDone);
      err_q   <= (state_d == StTimeout);
    end
  end

  assign act_o   = act_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_sensor_seq_ctrl.sv
// Directed self-checking bench for sensor_seq_ctrl with N_CH=4, CNT_W=8, ACT_CYC=3.
module tb_sensor_seq_ctrl;
  import sensor_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] evt_i;
  logic       en_i;
  logic       clr_i;
  logic [7:0] timeout_i;
  logic [3:0] seen_o;
  logic [1:0] first_o;
  logic       first_vld_o;
  logic       act_o;
  logic       done_o;
  logic       err_o;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  sensor_seq_ctrl #(
    .N_CH    (4),
    .CNT_W   (8),
    .ACT_CYC (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .evt_i       (evt_i),
    .en_i        (en_i),
    .clr_i       (clr_i),
    .timeout_i   (timeout_i),
    .seen_o      (seen_o),
    .first_o     (first_o),
    .first_vld_o (first_vld_o),
    .act_o       (act_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      evt_i = 4'($urandom_range(0, 15));
      en_i  = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    if (state_o !== 3'd0) begin
      errors++; $display("FAIL reset_state got %0d want 0", state_o);
    end
    checks++;
    if (seen_o !== 4'b0000) begin
      errors++; $display("FAIL reset_seen got %b want 0000", seen_o);
    end
    checks++;
    if ({act_o, done_o, err_o, first_vld_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got act/done/err/vld=%b want 0000",
               {act_o, done_o, err_o, first_vld_o});
    end
    rst   = 1'b0;
    evt_i = '0;
    en_i  = 1'b0;
    tick();
  endtask

  task automatic test_ordered();
    timeout_i = 8'd0;
    evt_i = 4'b0010; tick();
    checks++;
    if (seen_o !== 4'b0010 || first_o !== 2'd1 || first_vld_o !== 1'b1 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL ordered_first got seen=%b first=%0d vld=%b st=%0d want 0010/1/1/1",
               seen_o, first_o, first_vld_o, state_o);
    end
    evt_i = 4'b0000; tick();
    evt_i = 4'b1000; tick();
    checks++;
    if (seen_o !== 4'b1010 || first_o !== 2'd1 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL ordered_second got seen=%b first=%0d st=%0d want 1010/1/1",
               seen_o, first_o, state_o);
    end
    evt_i = 4'b0000; tick();
    evt_i = 4'b0101; tick();
    checks++;
    if (seen_o !== 4'b1111 || state_o !== 3'd2) begin
      errors++;
      $display("FAIL ordered_armed got seen=%b st=%0d want 1111/2", seen_o, state_o);
    end
    evt_i = 4'b0000; tick(); tick();
    checks++;
    if (state_o !== 3'd2 || act_o !== 1'b0) begin
      errors++;
      $display("FAIL ordered_wait_en got st=%0d act=%b want 2/0", state_o, act_o);
    end
    en_i = 1'b1; tick();
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_o !== 1'b1 || state_o !== 3'd3 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL ordered_act%0d got act=%b st=%0d done=%b want 1/3/0",
                 i, act_o, state_o, done_o);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_o !== 1'b0 || done_o !== 1'b1 || state_o !== 3'd4) begin
        errors++;
        $display("FAIL ordered_done%0d got act=%b done=%b st=%0d want 0/1/4",
                 i, act_o, done_o, state_o);
      end
      evt_i = 4'b0001;
      tick();
    end
    evt_i = '0;
    do_clear();
    checks++;
    if (state_o !== 3'd0 || seen_o !== 4'b0000 || done_o !== 1'b0 || first_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL ordered_clear got st=%0d seen=%b done=%b vld=%b want 0/0000/0/0",
               state_o, seen_o, done_o, first_vld_o);
    end
  endtask

  task automatic test_simultaneous();
    timeout_i = 8'd4;
    evt_i = 4'b0110; tick();
    checks++;
    if (first_o !== 2'd1 || state_o !== 3'd1 || seen_o !== 4'b0110) begin
      errors++;
      $display("FAIL simul_first got first=%0d st=%0d seen=%b want 1/1/0110",
               first_o, state_o, seen_o);
    end
    evt_i = 4'b0000;
    tick(); tick(); tick();
    checks++;
    if (state_o !== 3'd1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL simul_collect got st=%0d err=%b want 1/0", state_o, err_o);
    end
    // Counter now sits on timeout-1: completion must win.
    evt_i = 4'b1001; tick();
    evt_i = 4'b0000;
    checks++;
    if (state_o !== 3'd2 || err_o !== 1'b0 || seen_o !== 4'b1111 || first_o !== 2'd1) begin
      errors++;
      $display("FAIL simul_race got st=%0d err=%b seen=%b first=%0d want 2/0/1111/1",
               state_o, err_o, seen_o, first_o);
    end
    do_clear();
  endtask

  task automatic test_timeout();
    int bad;
    timeout_i = 8'd10;
    evt_i = 4'b0001; tick();
    evt_i = 4'b0000;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (state_o !== 3'd1 || err_o !== 1'b0) bad++;
      if (i < 9) tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL timeout_collect_len got %0d bad cycles want 0", bad);
    end
    tick();
    checks++;
    if (state_o !== 3'd5 || err_o !== 1'b1 || seen_o !== 4'b0001 || first_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hit got st=%0d err=%b seen=%b vld=%b want 5/1/0001/1",
               state_o, err_o, seen_o, first_vld_o);
    end
    evt_i = 4'b1110; en_i = 1'b1; tick(); tick();
    evt_i = 4'b0000; en_i = 1'b0;
    checks++;
    if (state_o !== 3'd5 || err_o !== 1'b1 || seen_o !== 4'b0001 || first_o !== 2'd0) begin
      errors++;
      $display("FAIL timeout_hold got st=%0d err=%b seen=%b first=%0d want 5/1/0001/0",
               state_o, err_o, seen_o, first_o);
    end
    do_clear();
    checks++;
    if ({state_o, seen_o, first_o, first_vld_o, act_o, done_o, err_o} !== 14'd0) begin
      errors++;
      $display("FAIL timeout_clear got st=%0d seen=%b first=%0d vld=%b err=%b want all 0",
               state_o, seen_o, first_o, first_vld_o, err_o);
    end
  endtask

  task automatic test_no_timeout();
    int bad;
    timeout_i = 8'd0;
    evt_i = 4'b0100; tick();
    evt_i = 4'b0000;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (state_o !== 3'd1 || err_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL no_timeout got %0d bad cycles want 0", bad);
    end
    do_clear();
  endtask

  task automatic test_clear_active();
    timeout_i = 8'd0;
    en_i = 1'b1; tick();
    en_i = 1'b0;
    evt_i = 4'b1111; tick();
    evt_i = 4'b0000; tick();
    checks++;
    if (state_o !== 3'd2 || act_o !== 1'b0 || first_o !== 2'd0) begin
      errors++;
      $display("FAIL en_not_remembered got st=%0d act=%b first=%0d want 2/0/0",
               state_o, act_o, first_o);
    end
    en_i = 1'b1; tick();
    en_i = 1'b0; tick();
    checks++;
    if (act_o !== 1'b1 || state_o !== 3'd3) begin
      errors++; $display("FAIL clr_act_2nd got act=%b st=%0d want 1/3", act_o, state_o);
    end
    clr_i = 1'b1; tick();
    clr_i = 1'b0;
    checks++;
    if (act_o !== 1'b0 || state_o !== 3'd0 || done_o !== 1'b0 || seen_o !== 4'b0000) begin
      errors++;
      $display("FAIL clr_active got act=%b st=%0d done=%b seen=%b want 0/0/0/0000",
               act_o, state_o, done_o, seen_o);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (done_o !== 1'b0 || state_o !== 3'd0) begin
      errors++; $display("FAIL clr_no_done got done=%b st=%0d want 0/0", done_o, state_o);
    end
    // Reset mid-pulse behaves like a clear.
    evt_i = 4'b1111; tick();
    evt_i = 4'b0000; en_i = 1'b1; tick();
    en_i = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    checks++;
    if (act_o !== 1'b0 || state_o !== 3'd0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_active got act=%b st=%0d done=%b want 0/0/0", act_o, state_o, done_o);
    end
  endtask

  task automatic test_illegal_state();
    @(negedge clk);
    force dut.state_q = state_e'(3'd6);
    #1;
    release dut.state_q;
    tick();
    checks++;
    if (state_o !== 3'd0 || seen_o !== 4'b0000 || err_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_state got st=%0d seen=%b err=%b done=%b want 0/0000/0/0",
               state_o, seen_o, err_o, done_o);
    end
  endtask

  initial begin
    rst       = 1'b1;
    evt_i     = '0;
    en_i      = 1'b0;
    clr_i     = 1'b0;
    timeout_i = '0;
    test_reset();
    test_ordered();
    test_simultaneous();
    test_timeout();
    test_no_timeout();
    test_clear_active();
    test_illegal_state();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
